// File: rtl/poly_lift_stream.sv
// Streaming HRSS lift: accumulates m1 = m/(x-1) mod (3, Phi_n) one input beat per cycle,
// then streams m0 = (x-1) * lift(m1 mod Phi_n) in Rq under a valid/ready handshake.
module poly_lift_stream #(
   parameter int unsigned NTRU_N       = 701,
   parameter int unsigned Q_BITS       = 13,
   parameter int unsigned COEF_PER_CYC = 2,
   parameter int unsigned OUT_PER_CYC  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [2*COEF_PER_CYC-1:0]       in_data,
   input  logic                            in_last,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [Q_BITS*OUT_PER_CYC-1:0]   out_data,
   output logic                            out_last,
   output logic                            busy,
   output logic                            err_len
);

   localparam int unsigned IN_BEATS  = (NTRU_N + COEF_PER_CYC - 1) / COEF_PER_CYC;
   localparam int unsigned OUT_BEATS = (NTRU_N + OUT_PER_CYC - 1) / OUT_PER_CYC;
   localparam int unsigned CW        = $clog2(IN_BEATS + 1);
   localparam int unsigned OW        = $clog2(OUT_BEATS + 1);
   localparam int unsigned AW        = $clog2(NTRU_N);
   localparam int unsigned NM3       = NTRU_N % 3;

   typedef enum logic [1:0] {IDLE, LOAD, NORM, DRAIN} state_t;

   state_t          state_q;
   logic [CW-1:0]   in_cnt_q;
   logic [OW-1:0]   out_cnt_q;
   logic            in_ready_q;
   logic            err_len_q;
   logic            early_q;
   logic [1:0]      acc_q [NTRU_N];
   logic [1:0]      acc_d [NTRU_N];

   logic            in_fire;
   logic [CW-1:0]   beat_idx;
   logic            is_final;
   logic            early_prev;

   function automatic logic [1:0] add3(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

   function automatic logic [1:0] neg3(input logic [1:0] a);
      case (a)
         2'd1:    return 2'd2;
         2'd2:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] mul3(input logic [1:0] a, input logic [1:0] b);
      if (a == 2'd0 || b == 2'd0) return 2'd0;
      return (a == b) ? 2'd1 : 2'd2;
   endfunction

   function automatic logic [1:0] code_val(input logic [1:0] c);
      return (c == 2'b11) ? 2'd0 : c;
   endfunction

   // (x-1)^-1 mod (x^n-1, up to Phi_n) has coefficient c_d = (d+1)/n mod 3; d = (i-k) mod n.
   function automatic logic [1:0] inv_coef(input int unsigned i, input int unsigned k);
      int unsigned t;
      t = (i % 3) + 4 - (k % 3) + ((i < k) ? NM3 : 32'd0);
      return mul3(2'(t % 3), 2'(NM3));
   endfunction

   function automatic logic [Q_BITS-1:0] lift(input logic [1:0] v);
      case (v)
         2'd1:    return Q_BITS'(1);
         2'd2:    return '1;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      in_fire    = in_valid & in_ready_q;
      beat_idx   = (state_q == IDLE) ? '0 : in_cnt_q;
      is_final   = (beat_idx == CW'(IN_BEATS - 1));
      early_prev = (state_q == IDLE) ? 1'b0 : early_q;
   end

   // NORM reduces in place (m2 = m1 - m1_(n-1)*Phi_n), so DRAIN reads m2 from acc_q.
   always_comb begin
      acc_d = acc_q;
      if (state_q == NORM) begin
         for (int unsigned i = 0; i < NTRU_N; i++)
            acc_d[AW'(i)] = add3(acc_q[AW'(i)], neg3(acc_q[AW'(NTRU_N - 1)]));
      end else if (in_fire) begin
         if (state_q == IDLE) acc_d = '{default: '0};
         for (int unsigned j = 0; j < COEF_PER_CYC; j++) begin
            if (32'(beat_idx) * COEF_PER_CYC + j < NTRU_N - 1) begin
               for (int unsigned i = 0; i < NTRU_N; i++)
                  acc_d[AW'(i)] = add3(acc_d[AW'(i)],
                     mul3(code_val(in_data[2*j +: 2]),
                          inv_coef(i, 32'(beat_idx) * COEF_PER_CYC + j)));
            end
         end
      end
   end

   // m0 = (x-1)*m2: m0_i = m2_(i-1) - m2_i, centred then taken mod 2^Q_BITS.
   always_comb begin
      out_data = '0;
      for (int unsigned j = 0; j < OUT_PER_CYC; j++) begin
         if (32'(out_cnt_q) * OUT_PER_CYC + j < NTRU_N) begin
            out_data[Q_BITS*j +: Q_BITS] =
               ((32'(out_cnt_q) * OUT_PER_CYC + j == 0) ? '0 :
                  lift(acc_q[AW'(32'(out_cnt_q) * OUT_PER_CYC + j - 1)]))
               - lift(acc_q[AW'(32'(out_cnt_q) * OUT_PER_CYC + j)]);
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == DRAIN);
   assign out_last  = (state_q == DRAIN) && (out_cnt_q == OW'(OUT_BEATS - 1));
   assign busy      = (state_q != IDLE);
   assign err_len   = err_len_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         in_ready_q <= 1'b0;
         err_len_q  <= 1'b0;
         early_q    <= 1'b0;
         acc_q      <= '{default: '0};
      end else begin
         acc_q <= acc_d;
         case (state_q)
            IDLE, LOAD: begin
               if (state_q == IDLE) in_ready_q <= 1'b1;
               if (in_fire) begin
                  if (is_final) begin
                     err_len_q  <= ~in_last | early_prev;
                     in_ready_q <= 1'b0;
                     in_cnt_q   <= '0;
                     state_q    <= NORM;
                  end else begin
                     if (state_q == IDLE) err_len_q <= 1'b0;
                     early_q  <= early_prev | in_last;
                     in_cnt_q <= beat_idx + 1'b1;
                     state_q  <= LOAD;
                  end
               end
            end
            NORM: begin
               out_cnt_q <= '0;
               state_q   <= DRAIN;
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_cnt_q  <= '0;
                     in_ready_q <= 1'b1;
                     state_q    <= IDLE;
                  end else begin
                     out_cnt_q <= out_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
